// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a 64x16 registered-read data memory.
// One access in flight; CPU and debug ports share the single memory port.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic              mem_dwe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic              PORT_CPU  = 1'b0;
  localparam logic              PORT_DBG  = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_LIM = DEPTH[ADDR_W:0];

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic                mem_dwe_q, mem_dwe_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_done_q, cpu_done_d;
  logic                cpu_err_q, cpu_err_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                dbg_done_q, dbg_done_d;
  logic                dbg_err_q, dbg_err_d;

  logic                cpu_elig, dbg_elig;
  logic                grant_valid, grant_port;
  logic                sel_we, sel_oor;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // A port whose done is high this cycle is still holding its finished request.
  assign cpu_elig    = cpu_req & ~cpu_done_q;
  assign dbg_elig    = dbg_req & ~dbg_done_q;
  assign grant_valid = cpu_elig | dbg_elig;
  assign grant_port  = dbg_elig & (~cpu_elig | (last_grant_q == PORT_CPU));

  assign sel_we    = grant_port ? dbg_we    : cpu_we;
  assign sel_addr  = grant_port ? dbg_addr  : cpu_addr;
  assign sel_wdata = grant_port ? dbg_wdata : cpu_wdata;
  assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_LIM);

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DBG;
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      oor_q        <= 1'b0;
      mem_dwe_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      cpu_err_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_done_q   <= 1'b0;
      dbg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      oor_q        <= oor_d;
      mem_dwe_q    <= mem_dwe_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_done_q   <= cpu_done_d;
      cpu_err_q    <= cpu_err_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_done_q   <= dbg_done_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = sel_oor ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    oor_d        = oor_q;
    mem_dwe_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_done_d   = 1'b0;
    cpu_err_d    = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_done_d   = 1'b0;
    dbg_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_port;
          port_d       = grant_port;
          we_d         = sel_we;
          oor_d        = sel_oor;
          // Out-of-range requests never touch the memory port.
          if (!sel_oor) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_dwe_d   = sel_we;
          end
        end
      end
      RESP: begin
        if (port_q == PORT_CPU) begin
          cpu_done_d = 1'b1;
          cpu_err_d  = oor_q;
          if (oor_q)      cpu_rdata_d = '0;
          else if (!we_q) cpu_rdata_d = mem_rdata;
        end else begin
          dbg_done_d = 1'b1;
          dbg_err_d  = oor_q;
          if (oor_q)      dbg_rdata_d = '0;
          else if (!we_q) dbg_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_err   = cpu_err_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_done  = dbg_done_q;
  assign dbg_err   = dbg_err_q;
  assign mem_dwe   = mem_dwe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64x16 registered-read memory model
// preloaded with mem[i] = 7*i - 3.
module tb_dmem_arbiter;

  logic        mem_clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_err;
  logic        dbg_req, dbg_we;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;
  logic        dbg_done, dbg_err;
  logic        mem_dwe;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int dwe_cnt = 0;
  int cpu_done_cnt = 0;
  int dbg_done_cnt = 0;

  logic [15:0] mem_model [64];
  bit          mem_loaded;

  always #5 mem_clk = ~mem_clk;

  dmem_arbiter dut (
    .mem_clk(mem_clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_err(dbg_err),
    .mem_dwe(mem_dwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Memory model: write-enable write, registered read (old data on same-edge write).
  always @(posedge mem_clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 16'(7 * i - 3);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_dwe) mem_model[mem_addr[5:0]] <= mem_wdata;
    end
    mem_rdata <= mem_model[mem_addr[5:0]];
  end

  always @(negedge mem_clk) begin
    if (mem_dwe)  dwe_cnt++;
    if (cpu_done) cpu_done_cnt++;
    if (dbg_done) dbg_done_cnt++;
  end

  // One access on one port; entered and left at #1 after a rising edge.
  task automatic access(input bit port, input bit we, input logic [7:0] addr,
                        input logic [15:0] wdata, output int lat,
                        output logic [15:0] rdata, output logic err);
    lat = -1; rdata = 'x; err = 'x;
    if (!port) begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end else begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge mem_clk); #1;
      if ((!port && cpu_done) || (port && dbg_done)) begin
        lat = c;
        rdata = port ? dbg_rdata : cpu_rdata;
        err   = port ? dbg_err : cpu_err;
        break;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(posedge mem_clk); #1;
    $display("%s %s addr=%h wdata=%h -> rdata=%h err=%b latency=%0d",
             port ? "dbg" : "cpu", we ? "write" : "read ", addr, wdata, rdata, err, lat);
  endtask

  task automatic test_reset;
    int lat; logic [15:0] rd; logic er;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (3) @(posedge mem_clk);
    #1;
    checks++;
    if ({cpu_rdata, cpu_done, cpu_err} !== 18'h0) begin
      errors++; $display("FAIL reset_cpu_outputs: got %h expected 0", {cpu_rdata, cpu_done, cpu_err});
    end
    checks++;
    if ({dbg_rdata, dbg_done, dbg_err} !== 18'h0) begin
      errors++; $display("FAIL reset_dbg_outputs: got %h expected 0", {dbg_rdata, dbg_done, dbg_err});
    end
    checks++;
    if ({mem_dwe, mem_addr, mem_wdata, busy} !== 26'h0) begin
      errors++; $display("FAIL reset_mem_outputs: got %h expected 0", {mem_dwe, mem_addr, mem_wdata, busy});
    end
    reset = 1'b1;
    @(posedge mem_clk); #1;
    access(1'b0, 1'b0, 8'd1, 16'h0, lat, rd, er);
    checks++;
    if (rd !== 16'h0004) begin errors++; $display("FAIL first_read_data: got %h expected 0004", rd); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL first_read_latency: got %0d expected 3", lat); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL first_read_err: got %b expected 0", er); end
  endtask

  task automatic test_write_read;
    int lat, d0; logic [15:0] rd; logic er;
    d0 = dwe_cnt;
    access(1'b1, 1'b1, 8'd10, 16'h1234, lat, rd, er);
    checks++;
    if (dwe_cnt - d0 !== 1) begin errors++; $display("FAIL write_dwe_cycles: got %0d expected 1", dwe_cnt - d0); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", lat); end
    checks++;
    if (dbg_rdata !== 16'h0000) begin errors++; $display("FAIL write_keeps_rdata: got %h expected 0000", dbg_rdata); end
    access(1'b0, 1'b0, 8'd10, 16'h0, lat, rd, er);
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL read_after_write: got %h expected 1234", rd); end
    checks++;
    if (dbg_rdata !== 16'h0000) begin errors++; $display("FAIL loser_rdata_untouched: got %h expected 0000", dbg_rdata); end
    checks++;
    if (dwe_cnt - d0 !== 1) begin errors++; $display("FAIL read_no_dwe: got %0d expected 1", dwe_cnt - d0); end
  endtask

  task automatic test_round_robin;
    int lat, cyc, ncpu, ndbg, last; logic [15:0] rd; logic er;
    int order[$];
    // A debug access first leaves last_grant=DBG, so the tie goes to CPU.
    access(1'b1, 1'b0, 8'd4, 16'h0, lat, rd, er);
    checks++;
    if (rd !== 16'h0019) begin errors++; $display("FAIL rr_pre_read: got %h expected 0019", rd); end
    cpu_we = 0; cpu_addr = 8'd2; dbg_we = 0; dbg_addr = 8'd3;
    cpu_req = 1; dbg_req = 1;
    ncpu = 0; ndbg = 0; last = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge mem_clk); #1;
      if (cpu_done) begin
        order.push_back(0); ncpu++;
        if (ncpu == 2) cpu_req = 0;
      end
      if (dbg_done) begin
        order.push_back(1); ndbg++;
        if (ndbg == 2) dbg_req = 0;
      end
      if (order.size() >= 4) begin last = cyc; break; end
    end
    cpu_req = 0; dbg_req = 0;
    $display("round robin: grants=%p last_done_cycle=%0d", order, last);
    while (order.size() < 4) order.push_back(9);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] !== (i % 2)) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 2);
      end
    end
    checks++;
    if (last !== 12) begin errors++; $display("FAIL rr_timing: got %0d expected 12", last); end
    checks++;
    if (cpu_rdata !== 16'h000B || dbg_rdata !== 16'h0012) begin
      errors++; $display("FAIL rr_rdata: got %h/%h expected 000b/0012", cpu_rdata, dbg_rdata);
    end
    @(posedge mem_clk); #1;
  endtask

  task automatic test_out_of_range;
    int lat, d0; logic [15:0] rd; logic er;
    d0 = dwe_cnt;
    access(1'b0, 1'b0, 8'h40, 16'h0, lat, rd, er);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", er); end
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL oor_rdata: got %h expected 0000", rd); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL oor_latency: got %0d expected 2", lat); end
    checks++;
    if (mem_addr !== 8'h03) begin errors++; $display("FAIL oor_mem_addr_held: got %h expected 03", mem_addr); end
    access(1'b1, 1'b1, 8'hFF, 16'hAAAA, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 16'h0000) begin
      errors++; $display("FAIL oor_write: got err=%b rdata=%h expected err=1 rdata=0000", er, rd);
    end
    checks++;
    if (dwe_cnt - d0 !== 0) begin errors++; $display("FAIL oor_no_dwe: got %0d expected 0", dwe_cnt - d0); end
    access(1'b0, 1'b0, 8'h3F, 16'h0, lat, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 16'h01B6 || lat !== 3) begin
      errors++; $display("FAIL last_addr: got err=%b rdata=%h lat=%0d expected err=0 rdata=01b6 lat=3", er, rd, lat);
    end
  endtask

  task automatic test_reset_mid_access;
    int lat, c0; logic [15:0] rd; logic er;
    cpu_we = 1; cpu_addr = 8'd0; cpu_wdata = 16'hBEEF; cpu_req = 1;
    @(posedge mem_clk); #1;
    checks++;
    if (busy !== 1'b1 || mem_dwe !== 1'b1) begin
      errors++; $display("FAIL mid_access_state: got busy=%b dwe=%b expected 1/1", busy, mem_dwe);
    end
    #1 reset = 1'b0;
    #1;
    cpu_req = 0;
    checks++;
    if (busy !== 1'b0 || mem_dwe !== 1'b0) begin
      errors++; $display("FAIL async_reset_clear: got busy=%b dwe=%b expected 0/0", busy, mem_dwe);
    end
    c0 = cpu_done_cnt;
    repeat (2) @(posedge mem_clk);
    #1;
    checks++;
    if (cpu_done_cnt !== c0) begin errors++; $display("FAIL dropped_no_done: got %0d expected %0d", cpu_done_cnt, c0); end
    reset = 1'b1;
    @(posedge mem_clk); #1;
    $display("reset during write access: busy=%b done_pulses=%0d", busy, cpu_done_cnt - c0);
    access(1'b0, 1'b0, 8'd0, 16'h0, lat, rd, er);
    checks++;
    if (rd !== 16'hFFFD || lat !== 3) begin
      errors++; $display("FAIL read_after_abort: got %h lat=%0d expected fffd lat=3", rd, lat);
    end
  endtask

  task automatic test_back_to_back;
    int c0, cyc, n;
    int done_cyc[3];
    logic [15:0] done_rd[3];
    // Request held through the done cycle must not be granted again.
    c0 = cpu_done_cnt;
    cpu_we = 0; cpu_addr = 8'd5; cpu_req = 1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge mem_clk); #1;
      if (cpu_done) break;
    end
    @(posedge mem_clk); #1;
    cpu_req = 0;
    repeat (4) @(posedge mem_clk);
    #1;
    $display("held req: done_pulses=%0d rdata=%h busy=%b", cpu_done_cnt - c0, cpu_rdata, busy);
    checks++;
    if (cpu_done_cnt - c0 !== 1) begin errors++; $display("FAIL no_duplicate_grant: got %0d expected 1", cpu_done_cnt - c0); end
    checks++;
    if (cpu_rdata !== 16'h0020) begin errors++; $display("FAIL held_read_data: got %h expected 0020", cpu_rdata); end
    // Continuous single-port requests: one access per 4 cycles.
    n = 0;
    for (int i = 0; i < 3; i++) begin done_cyc[i] = -1; done_rd[i] = 'x; end
    cpu_addr = 8'd6; cpu_req = 1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge mem_clk); #1;
      if (cpu_done) begin
        done_cyc[n] = cyc; done_rd[n] = cpu_rdata; n++;
        cpu_addr = 8'd7;
        if (n == 3) begin cpu_req = 0; break; end
      end
    end
    cpu_req = 0;
    for (int i = 0; i < 3; i++) begin
      $display("back-to-back read %0d: done_cycle=%0d rdata=%h", i, done_cyc[i], done_rd[i]);
      checks++;
      if (done_cyc[i] !== 3 + 4 * i) begin
        errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, done_cyc[i], 3 + 4 * i);
      end
    end
    checks++;
    if (done_rd[0] !== 16'h0027 || done_rd[1] !== 16'h002E || done_rd[2] !== 16'h002E) begin
      errors++; $display("FAIL b2b_data: got %h %h %h expected 0027 002e 002e", done_rd[0], done_rd[1], done_rd[2]);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_round_robin;
    test_out_of_range;
    test_reset_mid_access;
    test_back_to_back;
    repeat (2) @(posedge mem_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
